// File: rtl/bm_pkg.sv
// Shared constants, enums and the column-to-third helper for the binarized raster writer.
package bm_pkg;

    localparam int THIRD_W    = 240;
    localparam int CENTER_W   = 304;
    localparam int IMG_H      = 480;
    localparam int ROW_W      = 2 * THIRD_W + CENTER_W;
    localparam int END_THIRD  = THIRD_W * IMG_H / 16;
    localparam int END_CENTER = CENTER_W * IMG_H / 16;

    typedef enum logic [1:0] {
        THIRD_L = 2'd0,
        THIRD_C = 2'd1,
        THIRD_R = 2'd2
    } third_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } writer_state_t;

    function automatic third_t third_of(input logic [9:0] col, input logic [9:0] tw,
                                        input logic [9:0] cw);
        if (col < tw) begin
            return THIRD_L;
        end else if (col < tw + cw) begin
            return THIRD_C;
        end else begin
            return THIRD_R;
        end
    endfunction

endpackage

// File: rtl/bit_pix_raster_writer_packer.sv
// bit_pix_packer16: gathers 16 consecutive pixels into one word, bit0 = leftmost pixel.
module bit_pix_packer16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        clear,
    input  logic        bit_in,
    output logic [15:0] word,
    output logic        word_valid
);

    logic [15:0] sr_r;
    logic [3:0]  cnt_r;
    logic [3:0]  pos_s;

    // A clear pixel is slot 0 of a fresh word; the completed word is exposed combinationally.
    always_comb begin
        pos_s       = clear ? 4'd0 : cnt_r;
        word        = sr_r;
        word[pos_s] = bit_in;
        word_valid  = in_valid & (pos_s == 4'd15);
    end

    // Shift state: write the pixel into its slot and advance the slot pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r  <= 16'd0;
            cnt_r <= 4'd0;
        end else if (in_valid) begin
            sr_r[pos_s] <= bit_in;
            cnt_r       <= pos_s + 4'd1;
        end else begin
            sr_r  <= sr_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/bit_pix_raster_writer.sv
// Packs a binarized raster into 16-px BRAM words per third, double-buffered per frame.
// Optional BIT_PIX_WR_STATS_EN adds saturating drop_count / abort_count outputs.
module bit_pix_raster_writer #(
    parameter int THIRD_W  = bm_pkg::THIRD_W,
    parameter int CENTER_W = bm_pkg::CENTER_W,
    parameter int IMG_H    = bm_pkg::IMG_H
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_data,
    input  logic        bm_idle,
    input  logic        bm_working_buf,
    output logic [15:0] wr_address,
    output logic [1:0]  wr_third,
    output logic [15:0] wr_writedata,
    output logic        wr_write,
    output logic        buf_out_index,
    output logic [31:0] image_number,
    output logic        frame_done,
    output logic        frame_dropped
`ifdef BIT_PIX_WR_STATS_EN
    ,
    output logic [15:0] drop_count,
    output logic [15:0] abort_count
`endif
);

    import bm_pkg::*;

    localparam logic [9:0]  TW       = 10'(THIRD_W);
    localparam logic [9:0]  CW       = 10'(CENTER_W);
    localparam logic [9:0]  LAST_COL = 10'(2 * THIRD_W + CENTER_W - 1);
    localparam logic [8:0]  LAST_ROW = 9'(IMG_H - 1);
    localparam logic [15:0] END_T    = 16'(THIRD_W * IMG_H / 16);
    localparam logic [15:0] END_C    = 16'(CENTER_W * IMG_H / 16);

    writer_state_t state_r;
    logic [9:0]    col_r;
    logic [8:0]    row_r;
    logic [15:0]   cnt_l_r, cnt_c_r, cnt_rt_r;

    logic          accept_s, take_s, last_s, word_valid_s;
    logic [9:0]    cur_col_s;
    logic [8:0]    cur_row_s;
    third_t        third_s;
    logic [15:0]   local_s, offset_s, addr_s, word_s;

    bit_pix_packer16 u_packer (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (take_s),
        .clear      (pix_sof),
        .bit_in     (pix_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Pixel acceptance, raster position of the current pixel and its BRAM address.
    always_comb begin
        accept_s  = bm_idle | (bm_working_buf != buf_out_index);
        cur_col_s = pix_sof ? 10'd0 : col_r;
        cur_row_s = pix_sof ? 9'd0 : row_r;
        if (!pix_valid) begin
            take_s = 1'b0;
        end else if (state_r == ACTIVE) begin
            take_s = 1'b1;
        end else begin
            take_s = pix_sof & accept_s;
        end
        last_s  = take_s & (cur_row_s == LAST_ROW) & (cur_col_s == LAST_COL);
        third_s = third_of(cur_col_s, TW, CW);
        case (third_s)
            THIRD_L: begin local_s = cnt_l_r;  offset_s = END_T; end
            THIRD_C: begin local_s = cnt_c_r;  offset_s = END_C; end
            THIRD_R: begin local_s = cnt_rt_r; offset_s = END_T; end
            default: begin local_s = cnt_rt_r; offset_s = END_T; end
        endcase
        addr_s = buf_out_index ? (local_s + offset_s) : local_s;
    end

    // Writer FSM, raster counters, word counters and registered BRAM/frame outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            col_r         <= 10'd0;
            row_r         <= 9'd0;
            cnt_l_r       <= 16'd0;
            cnt_c_r       <= 16'd0;
            cnt_rt_r      <= 16'd0;
            wr_address    <= 16'd0;
            wr_third      <= 2'd0;
            wr_writedata  <= 16'd0;
            wr_write      <= 1'b0;
            buf_out_index <= 1'b0;
            image_number  <= 32'd0;
            frame_done    <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            wr_write      <= 1'b0;
            frame_done    <= 1'b0;
            frame_dropped <= 1'b0;
            // The flip lands one cycle after frame_done so the final write keeps the old buffer.
            if (frame_done) begin
                buf_out_index <= ~buf_out_index;
                image_number  <= image_number + 32'd1;
            end
            if (take_s) begin
                if (pix_sof) begin
                    cnt_l_r  <= 16'd0;
                    cnt_c_r  <= 16'd0;
                    cnt_rt_r <= 16'd0;
                end else if (word_valid_s) begin
                    wr_write     <= 1'b1;
                    wr_address   <= addr_s;
                    wr_third     <= third_s;
                    wr_writedata <= word_s;
                    case (third_s)
                        THIRD_L: cnt_l_r  <= local_s + 16'd1;
                        THIRD_C: cnt_c_r  <= local_s + 16'd1;
                        default: cnt_rt_r <= local_s + 16'd1;
                    endcase
                end
                if (last_s) begin
                    col_r      <= 10'd0;
                    row_r      <= 9'd0;
                    state_r    <= IDLE;
                    frame_done <= 1'b1;
                end else if (cur_col_s == LAST_COL) begin
                    col_r   <= 10'd0;
                    row_r   <= cur_row_s + 9'd1;
                    state_r <= ACTIVE;
                end else begin
                    col_r   <= cur_col_s + 10'd1;
                    row_r   <= cur_row_s;
                    state_r <= ACTIVE;
                end
            end else if (pix_valid && pix_sof) begin
                state_r       <= DROP;
                frame_dropped <= 1'b1;
            end
        end
    end

`ifdef BIT_PIX_WR_STATS_EN
    // Saturating counters of rejected and aborted frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count  <= 16'd0;
            abort_count <= 16'd0;
        end else begin
            if (pix_valid && pix_sof && !take_s && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (pix_valid && pix_sof && (state_r == ACTIVE) && (abort_count != 16'hFFFF)) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bit_pix_raster_writer.sv
// Scoreboard bench for bit_pix_raster_writer on a reduced raster (32|48|32 x 4 rows).
// Build with +define+BIT_PIX_WR_STATS_EN to also check drop_count / abort_count.
module tb_bit_pix_raster_writer;

    localparam int TW  = 32;
    localparam int CW  = 48;
    localparam int IH  = 4;
    localparam int RW  = 2 * TW + CW;
    localparam int ET  = TW * IH / 16;
    localparam int EC  = CW * IH / 16;
    localparam int WPF = RW * IH / 16;
    localparam int NPX = RW * IH;

    logic        clk = 1'b0;
    logic        reset, pix_valid, pix_sof, pix_data, bm_idle, bm_working_buf;
    logic [15:0] wr_address, wr_writedata;
    logic [1:0]  wr_third;
    logic        wr_write, buf_out_index, frame_done, frame_dropped;
    logic [31:0] image_number;
`ifdef BIT_PIX_WR_STATS_EN
    logic [15:0] drop_count, abort_count;
`endif

    bit_pix_raster_writer #(.THIRD_W(TW), .CENTER_W(CW), .IMG_H(IH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_valid      (pix_valid),
        .pix_sof        (pix_sof),
        .pix_data       (pix_data),
        .bm_idle        (bm_idle),
        .bm_working_buf (bm_working_buf),
        .wr_address     (wr_address),
        .wr_third       (wr_third),
        .wr_writedata   (wr_writedata),
        .wr_write       (wr_write),
        .buf_out_index  (buf_out_index),
        .image_number   (image_number),
        .frame_done     (frame_done),
        .frame_dropped  (frame_dropped)
`ifdef BIT_PIX_WR_STATS_EN
        ,
        .drop_count     (drop_count),
        .abort_count    (abort_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks = 0, errors = 0;
    int  writes_seen = 0, done_seen = 0, drop_seen = 0;
    logic        cap_first = 1'b0;
    logic [1:0]  f_t;
    logic [15:0] f_a, f_d;

    // reference model state
    logic        m_active = 1'b0, m_buf = 1'b0;
    int          m_col = 0, m_row = 0, m_img = 0;
    logic [15:0] m_word = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_write) begin
            writes_seen++;
            if (cap_first) begin
                f_t = wr_third; f_a = wr_address; f_d = wr_writedata;
                cap_first = 1'b0;
            end
            if (sb.size() == 0) begin
                check_val("unexpected_write", {31'd0, wr_write}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check_val("wr_third", {30'd0, wr_third}, {30'd0, e.t});
                check_val("wr_address", {16'd0, wr_address}, {16'd0, e.a});
                check_val("wr_writedata", {16'd0, wr_writedata}, {16'd0, e.d});
            end
        end
        if (frame_done) done_seen++;
        if (frame_dropped) drop_seen++;
    end

    task automatic model_px(input logic sof, input logic d);
        wr_t e;
        int  start, wpr, endv;
        if (sof) begin
            if (m_active || bm_idle || (bm_working_buf != m_buf)) begin
                m_active = 1'b1; m_col = 0; m_row = 0;
            end else begin
                m_active = 1'b0;
            end
        end
        if (m_active) begin
            m_word[m_col % 16] = d;
            if (m_col % 16 == 15) begin
                if (m_col < TW) begin
                    e.t = 2'd0; start = 0; wpr = TW / 16; endv = ET;
                end else if (m_col < TW + CW) begin
                    e.t = 2'd1; start = TW; wpr = CW / 16; endv = EC;
                end else begin
                    e.t = 2'd2; start = TW + CW; wpr = TW / 16; endv = ET;
                end
                e.a = 16'(m_row * wpr + (m_col - start) / 16 + (m_buf ? endv : 0));
                e.d = m_word;
                sb.push_back(e);
            end
            if (m_col == RW - 1) begin
                m_col = 0;
                if (m_row == IH - 1) begin
                    m_active = 1'b0; m_buf = ~m_buf; m_img++;
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic drive_px(input logic sof, input logic d, input bit gaps);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        pix_valid = 1'b1; pix_sof = sof; pix_data = d;
        model_px(sof, d);
        @(posedge clk);
        #1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 1'b0;
    endtask

    task automatic send_frame(input int npix, input bit rnd, input bit gaps, input bit settle);
        int  col;
        logic d;
        for (int p = 0; p < npix; p++) begin
            col = p % RW;
            d   = rnd ? 1'($urandom_range(0, 1)) : col[0];
            drive_px(p == 0, d, gaps);
        end
        if (settle) begin
            repeat (5) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 1'b0;
        bm_idle = 1'b1; bm_working_buf = 1'b0;
        @(negedge clk);
        check_val("rst_wr_write", {31'd0, wr_write}, 32'd0);
        check_val("rst_wr_address", {16'd0, wr_address}, 32'd0);
        check_val("rst_buf", {31'd0, buf_out_index}, 32'd0);
        check_val("rst_img", image_number, 32'd0);
        check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_val("rst_frame_dropped", {31'd0, frame_dropped}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: first frame, pix_data = col[0]
        w0 = writes_seen; cap_first = 1'b1;
        send_frame(NPX, 1'b0, 1'b0, 1'b1);
        check_val("t1_first_third", {30'd0, f_t}, 32'd0);
        check_val("t1_first_addr", {16'd0, f_a}, 32'd0);
        check_val("t1_first_data", {16'd0, f_d}, 32'h0000AAAA);
        check_val("t1_writes", writes_seen - w0, WPF);
        check_val("t1_done", done_seen, 1);
        check_val("t1_buf", {31'd0, buf_out_index}, 32'd1);
        check_val("t1_img", image_number, 32'd1);
        check_val("t1_sb_empty", sb.size(), 0);

        // 2: second frame lands in buffer 1
        cap_first = 1'b1;
        send_frame(NPX, 1'b1, 1'b0, 1'b1);
        check_val("t2_first_addr", {16'd0, f_a}, ET);
        check_val("t2_buf", {31'd0, buf_out_index}, 32'd0);
        check_val("t2_img", image_number, 32'd2);
        check_val("t2_sb_empty", sb.size(), 0);

        // 3: matcher busy on the buffer to be written -> drop
        bm_idle = 1'b0; bm_working_buf = m_buf;
        w0 = writes_seen;
        send_frame(NPX, 1'b0, 1'b0, 1'b1);
        check_val("t3_writes", writes_seen - w0, 0);
        check_val("t3_dropped", drop_seen, 1);
        check_val("t3_buf", {31'd0, buf_out_index}, 32'd0);
        check_val("t3_img", image_number, 32'd2);
        bm_idle = 1'b1;

        // 4: abort at pixel 100, then a full frame in the same buffer
        w0 = writes_seen;
        send_frame(100, 1'b1, 1'b0, 1'b1);
        check_val("t4_no_done", done_seen, 2);
        cap_first = 1'b1;
        send_frame(NPX, 1'b1, 1'b0, 1'b1);
        check_val("t4_restart_addr", {16'd0, f_a}, 32'd0);
        check_val("t4_writes", writes_seen - w0, 6 + WPF);
        check_val("t4_done", done_seen, 3);
        check_val("t4_img", image_number, 32'd3);
        check_val("t4_sb_empty", sb.size(), 0);
`ifdef BIT_PIX_WR_STATS_EN
        check_val("t4_abort_count", {16'd0, abort_count}, 32'd1);
        check_val("t4_drop_count", {16'd0, drop_count}, 32'd1);
`endif

        // 5: random pix_valid gaps
        w0 = writes_seen;
        send_frame(NPX, 1'b0, 1'b1, 1'b1);
        check_val("t5_writes", writes_seen - w0, WPF);
        check_val("t5_img", image_number, 32'd4);
        check_val("t5_sb_empty", sb.size(), 0);

        // 6: reset at row 2, then a clean frame
        send_frame(2 * RW, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        sb.delete();
        m_active = 1'b0; m_buf = 1'b0; m_img = 0;
        @(negedge clk);
        check_val("t6_rst_write", {31'd0, wr_write}, 32'd0);
        check_val("t6_rst_buf", {31'd0, buf_out_index}, 32'd0);
        check_val("t6_rst_img", image_number, 32'd0);
`ifdef BIT_PIX_WR_STATS_EN
        check_val("t6_rst_abort", {16'd0, abort_count}, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        cap_first = 1'b1;
        send_frame(NPX, 1'b0, 1'b0, 1'b1);
        check_val("t6_first_third", {30'd0, f_t}, 32'd0);
        check_val("t6_first_addr", {16'd0, f_a}, 32'd0);
        check_val("t6_img", image_number, 32'd1);
        check_val("t6_buf", {31'd0, buf_out_index}, 32'd1);
        check_val("t6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
